decoder_scan_nx: RTL and testbench
==================================

Name: decoder_scan_nx

Overview:
- Parametrised N-to-2^N decoder: generalises the 3x8 enabled decoder to any select width.
- Registered output; three modes: direct one-hot, direct thermometer, and autonomous scan (ring-strobe with programmable dwell).
- Used as a register-file write-enable decoder, a bus-slave select, or a row/digit strobe driver in the MIPS datapath and its peripherals.

Parameters:
N, 3, select width; OUTS = 2^N output lines (derived, not overridable)
DWELL_W, 8, width of the dwell-count input and internal dwell counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; 0 blanks outputs and pauses scan
mode  in  2  00 direct one-hot, 01 direct thermometer, 10 scan, 11 reserved
sel  in  N  select index, captured on load
load  in  1  capture strobe for sel
dwell  in  DWELL_W  scan: extra cycles each output stays active (0 = advance every cycle)
out  out  OUTS  registered decoded output
idx  out  N  current registered index
out_valid  out  1  out holds a decoded value (en=1 and mode != 11)
wrap  out  1  one-cycle pulse when scan index wraps OUTS-1 -> 0

Behaviour:
- Reset (async, rst_n=0): out=0, idx=0, out_valid=0, wrap=0, dwell counter cnt=0. Clean release on the next rising edge after rst_n rises.
- All outputs are registered. Inputs sampled at edge k appear on the outputs after edge k (latency 1).
- Next-state idx_n is computed first. out is then registered from idx_n and mode:
  - mode 00: one-hot, bit idx_n only.
  - mode 01: thermometer, bits 0..idx_n set, i.e. (2<<idx_n)-1. idx_n=OUTS-1 gives all ones.
  - mode 10: one-hot of idx_n.
- Blanking (en=0 or mode=11): out<=0, out_valid<=0, wrap<=0. idx and cnt hold, so scan resumes where it stopped. load is ignored.
- Direct modes (00/01), en=1:
  - load=1: idx<=sel.
  - Otherwise idx holds.
  - cnt<=0; wrap<=0; out_valid<=1.
  - A mode change 00<->01 without load re-renders the same idx on the next edge.
- Scan mode (10), en=1, out_valid<=1:
  - load=1 has priority: idx<=sel, cnt<=0, wrap<=0.
  - Else if cnt>=dwell: cnt<=0, idx<=idx+1 (mod OUTS), wrap<=1 iff idx==OUTS-1.
  - Else: cnt<=cnt+1, idx holds, wrap<=0.
  - The comparison is >=, so lowering dwell mid-step advances at the next edge and never stalls.
- Each output in scan is active for dwell+1 cycles. Full period = OUTS*(dwell+1) cycles.
- Entering scan from a direct mode: cnt is already 0 and the index starts from the held idx. First advance occurs after dwell+1 cycles.
- Leaving scan: cnt<=0. wrap never asserts outside mode 10.
- rst_n asserted mid-scan or mid-dwell: immediate return to the reset values, independent of clk.
- At most one bit of out is set in modes 00/10. out is never X after reset.

Test Plan:
- Reset and direct one-hot, N=3: mode=00, en=1, load=1 with sel=0..7 each cycle. Required: out=0x01,0x02,...,0x80, each one edge after its sel. Then en=0: out=0x00, out_valid=0, idx holds 7.
- Thermometer: mode=01, load sel=4. Required: out=0x1F. Switch to mode=00 with no load. Required: out=0x10 next edge. sel=7 in mode=01 gives out=0xFF.
- Scan with dwell=2: mode=10, en=1, starting from idx=0. Required:
  - each one-hot is held 3 cycles, 0x01 -> 0x02 -> ... -> 0x80 -> 0x01;
  - wrap=1 for exactly 1 cycle, coincident with out returning to 0x01;
  - period is 24 cycles.
- Pause and collision: during scan, drop en for 5 cycles mid-dwell. Required: out=0 and the scan resumes at the same idx and remaining dwell. Then assert load (sel=5) on the same edge the dwell would expire. Required: idx=5, out=0x20, cnt=0, wrap=0.
- Dwell edge cases: dwell=0 advances every cycle (8-cycle period). Changing dwell from 10 to 1 while cnt=6 advances on the next edge.
- Async reset: assert rst_n=0 between clock edges mid-scan. Required: out, idx, wrap, out_valid go to 0 immediately, and scan restarts from idx 0.

Source files
------------

// File: rtl/decoder_scan_nx_if.sv
// Interface bundling the control inputs and decoded outputs of decoder_scan_nx.
//   master: drives en, mode, sel, load, dwell; observes out, idx, out_valid, wrap
//   slave : the decoder itself (receives the controls, drives the outputs)
interface decoder_scan_nx_if #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
);
  localparam int OUTS = 1 << N;

  logic               en;
  logic [1:0]         mode;
  logic [N-1:0]       sel;
  logic               load;
  logic [DWELL_W-1:0] dwell;
  logic [OUTS-1:0]    out;
  logic [N-1:0]       idx;
  logic               out_valid;
  logic               wrap;

  modport master (
    output en, mode, sel, load, dwell,
    input  out, idx, out_valid, wrap
  );

  modport slave (
    input  en, mode, sel, load, dwell,
    output out, idx, out_valid, wrap
  );
endinterface

// File: rtl/decoder_scan_nx.sv
// N-to-2^N registered decoder with one-hot, thermometer and auto-scan modes.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : decoder_scan_nx_if.slave
//            en        global enable (0 blanks outputs, pauses scan)
//            mode      00 one-hot, 01 thermometer, 10 scan, 11 blank
//            sel/load  index capture
//            dwell     extra cycles per scan position
//            out       decoded lines, idx current index
//            out_valid out carries a decoded value
//            wrap      one-cycle pulse on scan wrap OUTS-1 -> 0
module decoder_scan_nx #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  decoder_scan_nx_if.slave bus
);
  localparam int OUTS = 1 << N;

  localparam logic [1:0] MODE_THERM = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  logic [N-1:0]       idx_q, idx_n;
  logic [DWELL_W-1:0] cnt_q, cnt_n;
  logic [OUTS-1:0]    out_q, out_n;
  logic               valid_q, valid_n;
  logic               wrap_q, wrap_n;
  logic               active;

  assign active = bus.en && (bus.mode != MODE_RSVD);

  always_comb begin
    // Blanked: idx and cnt hold so a paused scan resumes exactly where it left off.
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    wrap_n  = 1'b0;
    valid_n = 1'b0;
    out_n   = '0;

    if (active) begin
      valid_n = 1'b1;
      if (bus.mode == MODE_SCAN) begin
        if (bus.load) begin
          idx_n = bus.sel;
          cnt_n = '0;
        end else if (cnt_q >= bus.dwell) begin
          // >= rather than == so lowering dwell below cnt advances immediately.
          cnt_n  = '0;
          idx_n  = idx_q + N'(1);
          wrap_n = &idx_q;
        end else begin
          cnt_n = cnt_q + DWELL_W'(1);
        end
      end else begin
        cnt_n = '0;
        if (bus.load) idx_n = bus.sel;
      end

      // Render from the next index so the output tracks idx with no extra lag.
      for (int i = 0; i < OUTS; i++) begin
        if (bus.mode == MODE_THERM) out_n[i] = (i <= int'(idx_n));
        else                        out_n[i] = (i == int'(idx_n));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      out_q   <= out_n;
      valid_q <= valid_n;
      wrap_q  <= wrap_n;
    end
  end

  assign bus.out       = out_q;
  assign bus.idx       = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_decoder_scan_nx.sv
module tb_decoder_scan_nx;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   wraps;

  decoder_scan_nx_if #(.N(3), .DWELL_W(8)) bus ();

  decoder_scan_nx #(.N(3), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    wraps       = 0;
    bus.en      = 1'b0;
    bus.mode    = 2'b00;
    bus.sel     = '0;
    bus.load    = 1'b0;
    bus.dwell   = 8'd0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    #10;
    check("rst_out",   32'(bus.out), 32'h00);
    check("rst_idx",   32'(bus.idx), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_wrap",  32'(bus.wrap), 32'd0);
    step();
    rst_n = 1'b1;

    // Direct one-hot: each sel shows up one edge later
    bus.en = 1'b1; bus.mode = 2'b00; bus.load = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus.sel = 3'(s);
      step();
      check("onehot_out", 32'(bus.out), 32'(1) << s);
      check("onehot_valid", 32'(bus.out_valid), 32'd1);
    end

    // Blank with en=0: idx holds 7
    bus.en = 1'b0; bus.load = 1'b0;
    step();
    check("blank_out",   32'(bus.out), 32'h00);
    check("blank_valid", 32'(bus.out_valid), 32'd0);
    check("blank_idx",   32'(bus.idx), 32'd7);

    // Thermometer, then re-render as one-hot without load
    bus.en = 1'b1; bus.mode = 2'b01; bus.load = 1'b1; bus.sel = 3'd4;
    step();
    check("therm4", 32'(bus.out), 32'h1F);
    bus.load = 1'b0; bus.mode = 2'b00;
    step();
    check("rerender_onehot", 32'(bus.out), 32'h10);
    bus.mode = 2'b01; bus.load = 1'b1; bus.sel = 3'd7;
    step();
    check("therm7", 32'(bus.out), 32'hFF);

    // Scan with dwell=2 from idx 0: 3 cycles per output, 24-cycle period
    bus.mode = 2'b00; bus.sel = 3'd0;
    step();
    check("preload0", 32'(bus.out), 32'h01);
    bus.load = 1'b0; bus.mode = 2'b10; bus.dwell = 8'd2;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("scan2_out", 32'(bus.out), 32'(1) << ((k / 3) % 8));
      check("scan2_wrap", 32'(bus.wrap), (k == 24) ? 32'd1 : 32'd0);
      if (bus.wrap) wraps++;
    end
    check("scan2_wrap_count", 32'(wraps), 32'd1);

    // Pause mid-dwell (cnt=1) for 5 cycles
    step();
    check("pre_pause", 32'(bus.out), 32'h01);
    bus.en = 1'b0;
    for (int p = 0; p < 5; p++) begin
      step();
      check("pause_out",   32'(bus.out), 32'h00);
      check("pause_valid", 32'(bus.out_valid), 32'd0);
      check("pause_wrap",  32'(bus.wrap), 32'd0);
    end
    check("pause_idx", 32'(bus.idx), 32'd0);
    bus.en = 1'b1;
    step();
    check("resume_out", 32'(bus.out), 32'h01);
    // Dwell expires on this edge, but load wins
    bus.load = 1'b1; bus.sel = 3'd5;
    step();
    check("collide_idx",  32'(bus.idx), 32'd5);
    check("collide_out",  32'(bus.out), 32'h20);
    check("collide_wrap", 32'(bus.wrap), 32'd0);
    bus.load = 1'b0;
    // cnt restarted at 0: two more holds, then advance
    step();
    check("collide_hold1", 32'(bus.out), 32'h20);
    step();
    check("collide_hold2", 32'(bus.out), 32'h20);
    step();
    check("collide_adv", 32'(bus.out), 32'h40);

    // Dwell 0: advance every edge, 8-cycle period
    bus.load = 1'b1; bus.sel = 3'd0;
    step();
    check("d0_load", 32'(bus.out), 32'h01);
    bus.load = 1'b0; bus.dwell = 8'd0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("d0_out",  32'(bus.out), 32'(1) << (k % 8));
      check("d0_wrap", 32'(bus.wrap), (k == 8) ? 32'd1 : 32'd0);
    end

    // Lower dwell from 10 to 1 while cnt=6: advance on next edge
    bus.dwell = 8'd10; bus.load = 1'b1; bus.sel = 3'd2;
    step();
    bus.load = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("d10_hold", 32'(bus.out), 32'h04);
    bus.dwell = 8'd1;
    step();
    check("dwell_lower_adv", 32'(bus.out), 32'h08);
    check("dwell_lower_idx", 32'(bus.idx), 32'd3);

    // Async reset between edges mid-scan
    bus.dwell = 8'd2;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out",   32'(bus.out), 32'h00);
    check("arst_idx",   32'(bus.idx), 32'd0);
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_wrap",  32'(bus.wrap), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("restart1", 32'(bus.out), 32'h01);
    step();
    check("restart2", 32'(bus.out), 32'h01);
    step();
    check("restart3", 32'(bus.out), 32'h02);

    // Reserved mode blanks
    bus.mode = 2'b11;
    step();
    check("rsvd_out",   32'(bus.out), 32'h00);
    check("rsvd_valid", 32'(bus.out_valid), 32'd0);
    check("rsvd_idx",   32'(bus.idx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
